// File: rtl/mpy_share_pkg.sv
// Shared types and constants for the multiplier-sharing controller.
package mpy_share_pkg;

    localparam int unsigned DefW      = 4;
    localparam int unsigned DefMpyLat = 3;
    localparam int unsigned DefPw     = 2 * DefW;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StCapt,
        StResp
    } state_e;

    // Bits needed to index n items; never less than one so the result is a legal vector width.
    function automatic int unsigned idx_width(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((32'd1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mpy_rr_arb.sv
// Combinational round-robin pick: scans upward from ptr+1 with wrap.
module mpy_rr_arb
    import mpy_share_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IdW  = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IdW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IdW-1:0]  idx,
    output logic            any
);

    int unsigned     cand;
    logic [NREQ-1:0] rot;

    // First valid requester after the last winner gets the grant.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = 0;
        rot  = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = (32'(ptr) + k) % NREQ;
            rot  = req_valid >> cand;
            if (!any && rot[0]) begin
                any = 1'b1;
                idx = IdW'(cand);
                gnt = NREQ'(1) << cand;
            end
        end
    end

endmodule

// File: rtl/mpy_share_ctrl.sv
// Shares one registered multiplier between NREQ requesters, one op at a time.
module mpy_share_ctrl
    import mpy_share_pkg::*;
#(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned W       = DefW,
    parameter int unsigned MPY_LAT = DefMpyLat
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ*W-1:0]          req_a,
    input  logic [NREQ*W-1:0]          req_b,
    output logic [NREQ-1:0]            rsp_valid,
    input  logic [NREQ-1:0]            rsp_ready,
    output logic [2*W-1:0]             rsp_p,
    output logic [W-1:0]               mpy_a,
    output logic [W-1:0]               mpy_b,
    input  logic [2*W-1:0]             mpy_p,
    output logic                       busy,
    output logic [idx_width(NREQ)-1:0] gnt_id
);

    localparam int unsigned     IdW     = idx_width(NREQ);
    localparam int unsigned     CntW    = idx_width(MPY_LAT);
    localparam logic [CntW-1:0] CntLast = CntW'(MPY_LAT - 1);
    localparam logic [IdW-1:0]  PtrRst  = IdW'(NREQ - 1);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [IdW-1:0]  ptr_q, ptr_d;
    logic [IdW-1:0]  gnt_id_q, gnt_id_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d;
    logic [2*W-1:0]  p_q, p_d;
    logic [NREQ-1:0] rv_q, rv_d;

    logic [NREQ-1:0] arb_gnt;
    logic [IdW-1:0]  arb_idx;
    logic            arb_any;
    logic [W-1:0]    win_a, win_b;

    mpy_rr_arb #(
        .NREQ (NREQ),
        .IdW  (IdW)
    ) u_arb (
        .req_valid (req_valid),
        .ptr       (ptr_q),
        .gnt       (arb_gnt),
        .idx       (arb_idx),
        .any       (arb_any)
    );

    // Select the winner's operands from the packed buses.
    always_comb begin
        win_a = W'(req_a >> (32'(arb_idx) * W));
        win_b = W'(req_b >> (32'(arb_idx) * W));
    end

    // Next-state and handshake logic; operands stay frozen until the product is captured.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        gnt_id_d  = gnt_id_q;
        a_d       = a_q;
        b_d       = b_q;
        p_d       = p_q;
        rv_d      = rv_q;
        req_ready = '0;
        unique case (state_q)
            StIdle: begin
                req_ready = arb_gnt;
                if (arb_any) begin
                    a_d      = win_a;
                    b_d      = win_b;
                    gnt_id_d = arb_idx;
                    cnt_d    = '0;
                    state_d  = StWait;
                end
            end
            StWait: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntLast) state_d = StCapt;
            end
            StCapt: begin
                p_d     = mpy_p;
                rv_d    = NREQ'(1) << gnt_id_q;
                state_d = StResp;
            end
            StResp: begin
                // rv_q is one-hot on the granted port, so other ports' ready is masked off.
                if (|(rsp_ready & rv_q)) begin
                    rv_d    = '0;
                    ptr_d   = gnt_id_q;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (rst) req_ready = '0;
    end

    // State registers with asynchronous reset; an in-flight op is simply dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            ptr_q    <= PtrRst;
            gnt_id_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            p_q      <= '0;
            rv_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            gnt_id_q <= gnt_id_d;
            a_q      <= a_d;
            b_q      <= b_d;
            p_q      <= p_d;
            rv_q     <= rv_d;
        end
    end

    assign mpy_a     = a_q;
    assign mpy_b     = b_q;
    assign rsp_p     = p_q;
    assign rsp_valid = rv_q;
    assign gnt_id    = gnt_id_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_mpy_share_ctrl.sv
// Directed bench for mpy_share_ctrl with a behavioural registered multiplier.
module tb_mpy_share_ctrl;

    localparam int unsigned NREQ    = 2;
    localparam int unsigned W       = 4;
    localparam int unsigned MPY_LAT = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [1:0]      req_valid = '0;
    logic [1:0]      req_ready;
    logic [7:0]      req_a = '0;
    logic [7:0]      req_b = '0;
    logic [1:0]      rsp_valid;
    logic [1:0]      rsp_ready = 2'b11;
    logic [7:0]      rsp_p;
    logic [3:0]      mpy_a, mpy_b;
    logic [7:0]      mpy_p;
    logic            busy;
    logic [0:0]      gnt_id;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    mpy_share_ctrl #(
        .NREQ    (NREQ),
        .W       (W),
        .MPY_LAT (MPY_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_p     (rsp_p),
        .mpy_a     (mpy_a),
        .mpy_b     (mpy_b),
        .mpy_p     (mpy_p),
        .busy      (busy),
        .gnt_id    (gnt_id)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier model: product appears MPY_LAT edges after the operands change.
    logic [7:0] pipe [MPY_LAT];
    initial for (int i = 0; i < MPY_LAT; i++) pipe[i] = '0;
    always @(posedge clk) begin
        pipe[0] <= 8'(mpy_a) * 8'(mpy_b);
        for (int i = 1; i < MPY_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mpy_p = pipe[MPY_LAT-1];

    typedef struct {
        logic [1:0] v;
        logic [3:0] a0, b0, a1, b1;
        int         exp_id;
        logic [7:0] exp_p;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One complete op with rsp_ready already high; entered and left at posedge+1.
    task automatic do_op(input string name, input logic [1:0] v, input logic [3:0] a0,
                         input logic [3:0] b0, input logic [3:0] a1, input logic [3:0] b1,
                         input int exp_id, input logic [7:0] exp_p, output int acc);
        int k;
        logic [1:0] oh;
        oh = 2'(1 << exp_id);
        req_valid = v;
        req_a = {a1, a0};
        req_b = {b1, b0};
        #1;
        k = 0;
        while (req_ready == 2'b00 && k < 20) begin
            @(posedge clk); #2;
            k++;
        end
        chk({name, " req_ready"}, req_ready, oh);
        @(posedge clk); #1;
        acc = cyc;
        req_valid = '0;
        chk({name, " gnt_id"}, gnt_id, exp_id);
        chk({name, " busy"}, busy, 1);
        chk({name, " mpy_a"}, mpy_a, exp_id == 0 ? a0 : a1);
        chk({name, " mpy_b"}, mpy_b, exp_id == 0 ? b0 : b1);
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (rsp_valid == 2'b00 && k < 12);
        chk({name, " latency"}, k, 4);
        chk({name, " rsp_valid"}, rsp_valid, oh);
        chk({name, " rsp_p"}, rsp_p, exp_p);
        @(posedge clk); #1;
        chk({name, " rsp_done"}, rsp_valid, 0);
        chk({name, " idle"}, busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, last_acc;
        logic [3:0] kk;

        tbl[0] = '{2'b11, 4'h3, 4'h5, 4'h7, 4'h9, 0, 8'h0F};
        tbl[1] = '{2'b11, 4'h3, 4'h5, 4'h7, 4'h9, 1, 8'h3F};
        tbl[2] = '{2'b11, 4'h3, 4'h5, 4'h7, 4'h9, 0, 8'h0F};
        tbl[3] = '{2'b11, 4'h3, 4'h5, 4'h7, 4'h9, 1, 8'h3F};
        tbl[4] = '{2'b01, 4'hF, 4'hF, 4'h0, 4'h0, 0, 8'hE1};
        tbl[5] = '{2'b01, 4'h0, 4'hF, 4'h0, 4'h0, 0, 8'h00};
        tbl[6] = '{2'b10, 4'h0, 4'h0, 4'hF, 4'h1, 1, 8'h0F};
        tbl[7] = '{2'b11, 4'h2, 4'h3, 4'h9, 4'h9, 0, 8'h06};

        // Reset state, with requests pending to show req_ready is gated by rst.
        req_valid = 2'b11;
        #1 rst = 1'b1;
        #2;
        chk("rst req_ready", req_ready, 0);
        chk("rst busy", busy, 0);
        chk("rst rsp_valid", rsp_valid, 0);
        chk("rst rsp_p", rsp_p, 0);
        chk("rst mpy_a", mpy_a, 0);
        chk("rst gnt_id", gnt_id, 0);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid = '0;

        // Table: round robin, spacing and operand boundaries.
        last_acc = 0;
        for (int i = 0; i < 8; i++) begin
            do_op($sformatf("vec%0d", i), tbl[i].v, tbl[i].a0, tbl[i].b0, tbl[i].a1,
                  tbl[i].b1, tbl[i].exp_id, tbl[i].exp_p, acc);
            if (i > 0) chk($sformatf("vec%0d spacing", i), acc - last_acc, 6);
            last_acc = acc;
        end

        // Operand hold: scramble inputs during WAIT; operands and req_ready must not move.
        req_valid = 2'b01;
        req_a = 8'h04;
        req_b = 8'h06;
        @(posedge clk); #1;
        chk("hold accept", gnt_id, 0);
        for (int k = 1; k <= 4; k++) begin
            kk = 4'(k);
            req_a = {kk, ~kk};
            req_b = {~kk, kk};
            req_valid[1] = ~req_valid[1];
            req_valid[0] = 1'b0;
            @(posedge clk); #1;
            chk($sformatf("hold%0d mpy_a", k), mpy_a, 4'h4);
            chk($sformatf("hold%0d mpy_b", k), mpy_b, 4'h6);
            chk($sformatf("hold%0d req_ready", k), req_ready, 0);
        end
        chk("hold rsp_valid", rsp_valid, 2'b01);
        chk("hold rsp_p", rsp_p, 8'h18);
        do_op("hold next", 2'b10, 4'h0, 4'h0, 4'h5, 4'h5, 1, 8'h19, acc);

        // Backpressure on requester 1 while requester 0 waits; port 0 ready is ignored.
        rsp_ready = 2'b00;
        req_valid = 2'b10;
        req_a = 8'hA0;
        req_b = 8'hC0;
        @(posedge clk); #1;
        chk("bp accept", gnt_id, 1);
        req_valid = 2'b01;
        repeat (4) begin
            @(posedge clk); #1;
        end
        chk("bp rsp_valid", rsp_valid, 2'b10);
        chk("bp rsp_p", rsp_p, 8'h78);
        for (int k = 0; k < 5; k++) begin
            rsp_ready = 2'b01;
            @(posedge clk); #1;
            chk($sformatf("bp%0d rsp_valid", k), rsp_valid, 2'b10);
            chk($sformatf("bp%0d rsp_p", k), rsp_p, 8'h78);
            chk($sformatf("bp%0d req_ready", k), req_ready, 0);
            chk($sformatf("bp%0d busy", k), busy, 1);
        end
        rsp_ready = 2'b10;
        @(posedge clk); #1;
        chk("bp release busy", busy, 0);
        chk("bp release rsp_valid", rsp_valid, 0);
        chk("bp release req_ready", req_ready, 2'b01);
        req_valid = '0;
        rsp_ready = 2'b11;

        // Reset in the middle of WAIT.
        req_valid = 2'b01;
        req_a = 8'h05;
        req_b = 8'h05;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("mid rst busy", busy, 0);
        chk("mid rst mpy_a", mpy_a, 0);
        chk("mid rst mpy_b", mpy_b, 0);
        chk("mid rst rsp_p", rsp_p, 0);
        chk("mid rst rsp_valid", rsp_valid, 0);
        chk("mid rst gnt_id", gnt_id, 0);
        chk("mid rst req_ready", req_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid = 2'b11;
        #1;
        chk("post rst priority", req_ready, 2'b01);
        req_valid = '0;
        do_op("post rst req1", 2'b10, 4'h0, 4'h0, 4'h2, 4'h8, 1, 8'h10, acc);
        do_op("post rst both", 2'b11, 4'h3, 4'h3, 4'h1, 4'h1, 0, 8'h09, acc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
